// File: rtl/param_divider_if.sv
// Request/result bundle for param_divider: operands and mode in, status and results out.
interface param_divider_if #(
  parameter int N = 8
);
  logic         start;
  logic         signed_mode;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/param_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, with optional two's-complement
// operands handled by magnitude division plus a final sign fix-up.
module param_divider #(
  parameter int N = 8
) (
  input logic            clk,
  input logic            reset,
  param_divider_if.slave bus
);

  localparam int CW = ($clog2(N + 1) > 4) ? $clog2(N + 1) : 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_a;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_m;
  logic [N-1:0]  r_dvd;
  logic          r_sign_q;
  logic          r_sign_r;
  logic          r_zero;
  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_rem;
  logic          r_dbz;

  logic [N+1:0]  w_shift;
  logic          w_ge;
  logic [N:0]    w_diff;

  function automatic logic [N-1:0] f_neg(input logic signed [N-1:0] x);
    return -x;
  endfunction

  // Magnitude of a two's-complement value; the most-negative value maps to 2^(N-1).
  function automatic logic [N-1:0] f_mag(input logic signed [N-1:0] x);
    return x[N-1] ? f_neg(x) : x;
  endfunction

  assign w_shift = {r_a, r_q[N-1]};
  assign w_ge    = (w_shift >= {2'b00, r_m});
  assign w_diff  = w_shift[N:0] - {1'b0, r_m};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_dvd    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_zero   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_CALC;
            r_cnt   <= '0;
            r_a     <= '0;
            r_dvd   <= bus.dividend;
            r_zero  <= (bus.divisor == '0);
            if (bus.signed_mode) begin
              r_q      <= f_mag(bus.dividend);
              r_m      <= f_mag(bus.divisor);
              r_sign_q <= bus.dividend[N-1] ^ bus.divisor[N-1];
              r_sign_r <= bus.dividend[N-1];
            end else begin
              r_q      <= bus.dividend;
              r_m      <= bus.divisor;
              r_sign_q <= 1'b0;
              r_sign_r <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_a   <= w_ge ? w_diff : w_shift[N:0];
          r_q   <= {r_q[N-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          // A zero divisor reports the raw captured dividend, bypassing the sign fix.
          if (r_zero) begin
            r_quot <= '1;
            r_rem  <= r_dvd;
          end else begin
            r_quot <= r_sign_q ? f_neg(r_q) : r_q;
            r_rem  <= r_sign_r ? f_neg(r_a[N-1:0]) : r_a[N-1:0];
          end
          r_dbz   <= r_zero;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_param_divider.sv
// Directed bench for param_divider (N=8): reset, unsigned/signed results, divide-by-zero,
// ignored start while busy, reset abort and back-to-back throughput.
module tb_param_divider;

  localparam int N = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  param_divider_if #(.N(N)) bus ();

  param_divider #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and leaves the bench in the cycle where done is seen (lat = -1 on timeout).
  task automatic do_op(input logic sm, input logic [N-1:0] a, input logic [N-1:0] b,
                       output int lat);
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_vec++; if (bus.quotient !== 8'h00) begin n_err++; $display("FAIL reset_quot got %h want 00", bus.quotient); end
    n_vec++; if (bus.remainder !== 8'h00) begin n_err++; $display("FAIL reset_rem got %h want 00", bus.remainder); end
    n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [7:0] a[3]  = '{8'd200, 8'd255, 8'd13};
    logic [7:0] b[3]  = '{8'd7,   8'd1,   8'd200};
    logic [7:0] eq[3] = '{8'd28,  8'd255, 8'd0};
    logic [7:0] er[3] = '{8'd4,   8'd0,   8'd13};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, a[i], b[i], lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL u_lat[%0d] got %0d want 10", i, lat); end
      n_vec++; if (bus.quotient !== eq[i]) begin n_err++; $display("FAIL u_quot[%0d] got %0d want %0d", i, bus.quotient, eq[i]); end
      n_vec++; if (bus.remainder !== er[i]) begin n_err++; $display("FAIL u_rem[%0d] got %0d want %0d", i, bus.remainder, er[i]); end
      n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL u_dbz[%0d] got %b want 0", i, bus.div_by_zero); end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL u_busy_in_done[%0d] got %b want 1", i, bus.busy); end
      tick();
      n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL u_idle[%0d] got busy=%b done=%b want 0 0", i, bus.busy, bus.done); end
    end
  endtask

  task automatic test_signed();
    logic       sm[5] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
    logic [7:0] a[5]  = '{8'hF9, 8'h80, 8'h07, 8'hF9, 8'hF9};
    logic [7:0] b[5]  = '{8'h02, 8'hFF, 8'hFE, 8'hFE, 8'h02};
    logic [7:0] eq[5] = '{8'hFD, 8'h80, 8'hFD, 8'h03, 8'h7C};
    logic [7:0] er[5] = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h01};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(sm[i], a[i], b[i], lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL s_lat[%0d] got %0d want 10", i, lat); end
      n_vec++; if (bus.quotient !== eq[i]) begin n_err++; $display("FAIL s_quot[%0d] got %h want %h", i, bus.quotient, eq[i]); end
      n_vec++; if (bus.remainder !== er[i]) begin n_err++; $display("FAIL s_rem[%0d] got %h want %h", i, bus.remainder, er[i]); end
      n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL s_dbz[%0d] got %b want 0", i, bus.div_by_zero); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    logic       sm[3] = '{1'b0,  1'b1,  1'b1};
    logic [7:0] a[3]  = '{8'h55, 8'h55, 8'hF9};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(sm[i], a[i], 8'h00, lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL z_lat[%0d] got %0d want 10", i, lat); end
      n_vec++; if (bus.quotient !== 8'hFF) begin n_err++; $display("FAIL z_quot[%0d] got %h want ff", i, bus.quotient); end
      n_vec++; if (bus.remainder !== a[i]) begin n_err++; $display("FAIL z_rem[%0d] got %h want %h", i, bus.remainder, a[i]); end
      n_vec++; if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL z_dbz[%0d] got %b want 1", i, bus.div_by_zero); end
      bus.dividend = 8'h12;
      bus.divisor  = 8'h34;
      repeat (3) tick();
      n_vec++; if (bus.quotient !== 8'hFF || bus.remainder !== a[i] || bus.div_by_zero !== 1'b1 || bus.done !== 1'b0)
        begin n_err++; $display("FAIL z_hold[%0d] got q=%h r=%h z=%b d=%b want ff %h 1 0", i, bus.quotient, bus.remainder, bus.div_by_zero, bus.done, a[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int first = -1;
    logic [7:0] q_seen = '0;
    logic [7:0] r_seen = '0;
    bus.signed_mode = 1'b0;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    tick();
    for (int c = 1; c <= 25; c++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        if (first < 0) begin first = c; q_seen = bus.quotient; r_seen = bus.remainder; end
      end
      bus.start = (c == 3);
      if (c == 3) begin bus.dividend = 8'h10; bus.divisor = 8'h03; end
      tick();
    end
    bus.start = 1'b0;
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL ign_pulses got %0d want 1", pulses); end
    n_vec++; if (first !== 10) begin n_err++; $display("FAIL ign_lat got %0d want 10", first); end
    n_vec++; if (q_seen !== 8'd28 || r_seen !== 8'd4) begin n_err++; $display("FAIL ign_result got %0d r %0d want 28 r 4", q_seen, r_seen); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int lat;
    bus.signed_mode = 1'b0;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    n_vec++; if (bus.quotient !== 8'h00 || bus.remainder !== 8'h00 || bus.div_by_zero !== 1'b0)
      begin n_err++; $display("FAIL abort_outs got q=%h r=%h z=%b want 00 00 0", bus.quotient, bus.remainder, bus.div_by_zero); end
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
      tick();
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL abort_no_done got %0d active cycles want 0", pulses); end
    do_op(1'b0, 8'd255, 8'd255, lat);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL abort_fresh_lat got %0d want 10", lat); end
    n_vec++; if (bus.quotient !== 8'd1 || bus.remainder !== 8'd0)
      begin n_err++; $display("FAIL abort_fresh got q=%0d r=%0d want 1 0", bus.quotient, bus.remainder); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[3]  = '{8'd200, 8'd100, 8'h55};
    logic [7:0] b[3]  = '{8'd7,   8'd9,   8'h00};
    logic [7:0] eq[3] = '{8'd28,  8'd11,  8'hFF};
    logic [7:0] er[3] = '{8'd4,   8'd1,   8'h55};
    logic       ez[3] = '{1'b0,   1'b0,   1'b1};
    int dt[3]   = '{-1, -1, -1};
    int lows[3] = '{-1, -1, -1};
    int nd = 0;
    int low = 0;
    int idx = 0;
    int t = 0;
    logic acc;
    bus.signed_mode = 1'b0;
    bus.dividend = a[0];
    bus.divisor  = b[0];
    bus.start    = 1'b1;
    tick();
    t = 1;
    idx = 1;
    bus.dividend = a[1];
    bus.divisor  = b[1];
    while (nd < 3 && t < 80) begin
      acc = 1'b0;
      if (bus.done === 1'b1) begin
        dt[nd] = t;
        n_vec++; if (bus.quotient !== eq[nd] || bus.remainder !== er[nd] || bus.div_by_zero !== ez[nd])
          begin n_err++; $display("FAIL b2b_result[%0d] got q=%h r=%h z=%b want %h %h %b", nd, bus.quotient, bus.remainder, bus.div_by_zero, eq[nd], er[nd], ez[nd]); end
        if (nd > 0) lows[nd] = low;
        low = 0;
        nd++;
        if (nd == 3) bus.start = 1'b0;
      end
      if (bus.busy === 1'b0) begin
        low++;
        acc = bus.start;
      end
      tick();
      t++;
      if (acc) begin
        idx++;
        if (idx < 3) begin bus.dividend = a[idx]; bus.divisor = b[idx]; end
      end
    end
    bus.start = 1'b0;
    n_vec++; if (nd !== 3) begin n_err++; $display("FAIL b2b_count got %0d done pulses want 3", nd); end
    n_vec++; if (dt[0] !== 10) begin n_err++; $display("FAIL b2b_first_lat got %0d want 10", dt[0]); end
    n_vec++; if (dt[1] - dt[0] !== 11) begin n_err++; $display("FAIL b2b_gap1 got %0d want 11", dt[1] - dt[0]); end
    n_vec++; if (dt[2] - dt[1] !== 11) begin n_err++; $display("FAIL b2b_gap2 got %0d want 11", dt[2] - dt[1]); end
    n_vec++; if (lows[1] !== 1) begin n_err++; $display("FAIL b2b_idle1 got %0d want 1", lows[1]); end
    n_vec++; if (lows[2] !== 1) begin n_err++; $display("FAIL b2b_idle2 got %0d want 1", lows[2]); end
    repeat (2) tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_divider.md
PARAM_DIVIDER -- requirements
Module: param_divider

Interface
REQ-001 Parameter N, default 8, operand, quotient and remainder width in bits; SHALL accept any N >= 2.
REQ-002 Port clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  request; sampled only in IDLE.
REQ-005 Port signed_mode  input  1  0 = unsigned, 1 = two's-complement; captured with operands.
REQ-006 Port dividend  input  N  numerator; captured on accepted start.
REQ-007 Port divisor  input  N  denominator; captured on accepted start.
REQ-008 Port busy  output  1  high from the cycle after acceptance until done.
REQ-009 Port done  output  1  one-cycle pulse; results valid this cycle and after.
REQ-010 Port quotient  output  N  registered quotient.
REQ-011 Port remainder  output  N  registered remainder.
REQ-012 Port div_by_zero  output  1  registered flag; captured divisor was zero.

Function
REQ-013 FSM states IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-014 IDLE: start=1 SHALL capture operands and mode, then go to CALC; start=0 stays IDLE.
REQ-015 Capture: signed_mode=1 SHALL store magnitudes of operands plus sign flags (sign_q = sign_dividend XOR sign_divisor, sign_r = sign_dividend); unsigned stores raw values.
REQ-016 CALC: restoring division, one quotient bit per cycle, MSB first; (N+1)-bit partial remainder; 4-bit-or-wider iteration counter of width clog2(N+1).
REQ-017 Per iteration: shift {A,Q} left one; trial A-M; if non-negative, A=A-M and Q[0]=1, else A restored and Q[0]=0.
REQ-018 CALC SHALL last exactly N cycles, then go to FIX.
REQ-019 FIX: negate quotient if sign_q, negate remainder if sign_r (signed mode only); write quotient, remainder and div_by_zero output registers; go to DONE.
REQ-020 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-021 Latency: done high in the (N+2)th cycle after the start-accept edge (N=8: 10 cycles); constant for all operand values.
REQ-022 busy=1 in CALC, FIX, DONE; busy=0 in IDLE; start outside IDLE SHALL be ignored, with no queuing.
REQ-023 A new start is accepted in the IDLE cycle immediately after DONE; back-to-back throughput is one result per N+3 cycles.
REQ-024 Signed result: truncation toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-025 Signed most-negative / -1: quotient = most-negative value (wraps), remainder 0, no flag.
REQ-026 Divisor zero: quotient all-ones, remainder = captured dividend unmodified, div_by_zero=1, same latency, no sign fix.
REQ-027 quotient, remainder and div_by_zero SHALL hold between done pulses; inputs may change freely while busy.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal A, Q, M and counter cleared.
REQ-029 Reset during CALC, FIX or DONE SHALL abort the operation with no done pulse; reset dominates a simultaneous start.
REQ-030 First start is accepted in the first cycle after reset deasserts.

Verification (N=8)
REQ-031 Unsigned 200/7 -> quotient 28, remainder 4, div_by_zero 0, done exactly 10 cycles after accept.
REQ-032 Signed 0xF9(-7)/0x02 -> quotient 0xFD(-3), remainder 0xFF(-1); signed 0x80/0xFF -> quotient 0x80, remainder 0x00.
REQ-033 0x55/0x00, both modes -> quotient 0xFF, remainder 0x55, div_by_zero 1, done at cycle 10.
REQ-034 start pulsed with new operands during CALC -> ignored; first result unchanged; one done pulse only.
REQ-035 reset asserted at CALC cycle 4 -> all outputs 0 next cycle, no done; fresh 255/255 -> quotient 1, remainder 0.
REQ-036 Back-to-back: start held high -> results for successive captured operands, done pulses 11 cycles apart, busy low for exactly one cycle between them.
